fir_serial_mac: RTL

Parametrised, time-multiplexed FIR low-pass filter: one multiplier-accumulator computes y[n] = sum H[k]*x[n-k] over TAPS cycles per sample. Coefficients are runtime-loadable, and input/output use valid/ready handshakes. The output is rounded, scaled and saturated. It sits between the sample source (ECG/ADC path) and the UART transmit framer, and replaces the fully parallel fixed-coefficient filter where area matters more than throughput.

---
 rtl/fir_serial_mac.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR filter: one multiplier-accumulator walks all taps per sample,
// with runtime-loadable coefficients, valid/ready handshakes and a round/saturate output stage.
module fir_serial_mac #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 101,
    parameter int ACC_W  = 40,
    parameter int OUT_W  = 32,
    parameter int SHIFT  = 0
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    input  logic                      Coef_we,
    input  logic [$clog2(TAPS)-1:0]   Coef_addr,
    input  logic signed [COEF_W-1:0]  Coef_data,
    input  logic                      In_valid,
    output logic                      In_ready,
    input  logic signed [DATA_W-1:0]  Xin,
    output logic                      Out_valid,
    input  logic                      Out_ready,
    output logic signed [OUT_W-1:0]   Yout,
    output logic                      Sat_flag
);

    localparam int AW       = $clog2(TAPS);
    localparam int PROD_W   = DATA_W + COEF_W;
    localparam int HALF_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic [AW:0]             TAPS_V  = (AW + 1)'(TAPS);
    localparam logic [AW-1:0]           LAST_K  = AW'(TAPS - 1);
    localparam logic signed [ACC_W:0]   SAT_MAX = {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0]   SAT_MIN = {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};
    localparam logic [OUT_W-1:0]        OUT_MAX = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0]        OUT_MIN = {1'b1, {(OUT_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t state;

    logic signed [DATA_W-1:0] dline [TAPS];
    logic signed [COEF_W-1:0] coef  [TAPS];

    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            k_tap;
    logic [AW-1:0]            rd_idx;
    logic [AW:0]              diff_raw;
    logic                     mac_run;
    logic                     accept;
    logic                     coef_wr;

    logic signed [PROD_W-1:0] coef_ext;
    logic signed [PROD_W-1:0] data_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] prod_p0;
    logic                     vld_p0;
    logic                     last_p0;
    logic signed [ACC_W-1:0]  acc_p1;
    logic signed [ACC_W-1:0]  acc_sum;
    logic [OUT_W:0]           sat_res;

    // Round half up by adding 2^(SHIFT-1) one bit wider than the accumulator, then shift.
    function automatic logic signed [ACC_W:0] round_shift(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W:0] ext;
        logic signed [ACC_W:0] half;
        ext  = {a[ACC_W-1], a};
        half = (SHIFT > 0) ? ((ACC_W + 1)'(1) << HALF_POS) : '0;
        return (ext + half) >>> SHIFT;
    endfunction

    // Result packs {clamped, value}.
    function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W:0] r);
        if (r > SAT_MAX) begin
            return {1'b1, OUT_MAX};
        end else if (r < SAT_MIN) begin
            return {1'b1, OUT_MIN};
        end
        return {1'b0, r[OUT_W-1:0]};
    endfunction

    assign accept  = (state == IDLE) && In_valid && In_ready;
    assign coef_wr = (state == IDLE) && Coef_we && ({1'b0, Coef_addr} < TAPS_V);

    // Circular read: x[(wr_ptr - k) mod TAPS], folding a borrow back into range.
    always_comb begin
        diff_raw = {1'b0, wr_ptr} - {1'b0, k_tap};
        if (diff_raw[AW]) begin
            diff_raw = diff_raw + TAPS_V;
        end
        rd_idx = diff_raw[AW-1:0];
    end

    assign coef_ext = PROD_W'(coef[k_tap]);
    assign data_ext = PROD_W'(dline[rd_idx]);
    assign prod     = coef_ext * data_ext;
    assign acc_sum  = acc_p1 + {{(ACC_W - PROD_W){prod_p0[PROD_W-1]}}, prod_p0};
    assign sat_res  = saturate(round_shift(acc_sum));

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state     <= IDLE;
            In_ready  <= 1'b0;
            Out_valid <= 1'b0;
            Yout      <= '0;
            Sat_flag  <= 1'b0;
            wr_ptr    <= '0;
            k_tap     <= '0;
            mac_run   <= 1'b0;
            vld_p0    <= 1'b0;
            last_p0   <= 1'b0;
            prod_p0   <= '0;
            acc_p1    <= '0;
            for (int i = 0; i < TAPS; i++) begin
                dline[i] <= '0;
                coef[i]  <= '0;
            end
        end else begin
            if (coef_wr) begin
                coef[Coef_addr] <= Coef_data;
            end
            case (state)
                IDLE: begin
                    In_ready <= 1'b1;
                    if (accept) begin
                        dline[wr_ptr] <= Xin;
                        acc_p1        <= '0;
                        k_tap         <= '0;
                        mac_run       <= 1'b1;
                        vld_p0        <= 1'b0;
                        last_p0       <= 1'b0;
                        In_ready      <= 1'b0;
                        state         <= MAC;
                    end
                end
                MAC: begin
                    // stage p0: multiply one tap per cycle
                    vld_p0  <= mac_run;
                    last_p0 <= mac_run && (k_tap == LAST_K);
                    if (mac_run) begin
                        prod_p0 <= prod;
                        if (k_tap == LAST_K) begin
                            mac_run <= 1'b0;
                        end else begin
                            k_tap <= k_tap + 1'b1;
                        end
                    end
                    // stage p1: accumulate; last product feeds the output register directly
                    if (vld_p0) begin
                        acc_p1 <= acc_sum;
                        if (last_p0) begin
                            {Sat_flag, Yout} <= sat_res;
                            Out_valid        <= 1'b1;
                            wr_ptr           <= (wr_ptr == LAST_K) ? '0 : wr_ptr + 1'b1;
                            state            <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (Out_ready) begin
                        Out_valid <= 1'b0;
                        In_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
